// File: rtl/inst_fetcher.sv
// Instruction fetch front end: owns the PC, issues word fetches, hands words to the decoder.
// Optional FETCH_PERF_EN adds fetch/flush event counters.
module inst_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic [31:0] inst_out,
    output logic        inst_ready_out,
    output logic [31:0] inst_addr_out,
    output logic        clear_out,
    input  logic        stall_in,
    input  logic [31:0] next_pc_in,
    input  logic        flush_in,
    input  logic [31:0] flush_pc_in,
    input  logic        jalr_valid_in,
`ifdef FETCH_PERF_EN
    output logic [31:0] fetch_count_out,
    output logic [31:0] flush_count_out,
`endif
    input  logic [31:0] jalr_target_in
);

    typedef enum logic [2:0] {
        StReq,
        StWait,
        StDeliver,
        StHold,
        StDiscard
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic        inst_ready_q, inst_ready_d;
    logic        clear_q, clear_d;
    logic        deliver_evt;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_addr_d  = inst_addr_q;
        inst_ready_d = inst_ready_q;
        clear_d      = 1'b0;
        deliver_evt  = 1'b0;

        if (flush_in) begin
            pc_d         = flush_pc_in & ~32'h3;
            clear_d      = 1'b1;
            inst_ready_d = 1'b0;
            // A request accepted or still unanswered leaves a response that must be drained.
            unique case (state_q)
                StReq:     state_d = mem_req_ready  ? StDiscard : StReq;
                StWait:    state_d = mem_resp_valid ? StReq : StDiscard;
                StDiscard: state_d = mem_resp_valid ? StReq : StDiscard;
                default:   state_d = StReq;
            endcase
        end else begin
            unique case (state_q)
                StReq: begin
                    if (mem_req_ready) state_d = StWait;
                end
                StWait: begin
                    if (mem_resp_valid) begin
                        inst_d       = mem_resp_data;
                        inst_addr_d  = pc_q;
                        inst_ready_d = 1'b1;
                        deliver_evt  = 1'b1;
                        state_d      = StDeliver;
                    end
                end
                StDeliver: begin
                    inst_ready_d = 1'b0;
                    if (stall_in) begin
                        state_d = StHold;
                    end else begin
                        pc_d    = next_pc_in & ~32'h3;
                        state_d = StReq;
                    end
                end
                StHold: begin
                    if (jalr_valid_in) begin
                        pc_d    = jalr_target_in & ~32'h3;
                        state_d = StReq;
                    end
                end
                StDiscard: begin
                    if (mem_resp_valid) state_d = StReq;
                end
                default: state_d = StReq;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = deliver_evt ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
        flush_cnt_d = flush_in    ? flush_cnt_q + 32'd1 : flush_cnt_q;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            fetch_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else if (rdy_in) begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_count_out = fetch_cnt_q;
    assign flush_count_out = flush_cnt_q;
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= StReq;
            pc_q         <= RESET_PC & ~32'h3;
            inst_q       <= 32'd0;
            inst_addr_q  <= 32'd0;
            inst_ready_q <= 1'b0;
            clear_q      <= 1'b0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_addr_q  <= inst_addr_d;
            inst_ready_q <= inst_ready_d;
            clear_q      <= clear_d;
        end
    end

    assign mem_req_valid  = (state_q == StReq);
    assign mem_req_addr   = pc_q;
    assign inst_out       = inst_q;
    assign inst_addr_out  = inst_addr_q;
    assign inst_ready_out = inst_ready_q;
    assign clear_out      = clear_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Randomized bench for inst_fetcher: transaction-level model plus delivery scoreboard.
module tb_inst_fetcher;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int NCYC = 4000;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_resp_data;
    logic [31:0] inst_out, inst_addr_out;
    logic        inst_ready_out, clear_out;
    logic        stall_in, flush_in, jalr_valid_in;
    logic [31:0] next_pc_in, flush_pc_in, jalr_target_in;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_out, flush_count_out;
`endif

    inst_fetcher #(.RESET_PC(RESET_PC)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .inst_out       (inst_out),
        .inst_ready_out (inst_ready_out),
        .inst_addr_out  (inst_addr_out),
        .clear_out      (clear_out),
        .stall_in       (stall_in),
        .next_pc_in     (next_pc_in),
        .flush_in       (flush_in),
        .flush_pc_in    (flush_pc_in),
        .jalr_valid_in  (jalr_valid_in),
`ifdef FETCH_PERF_EN
        .fetch_count_out(fetch_count_out),
        .flush_count_out(flush_count_out),
`endif
        .jalr_target_in (jalr_target_in)
    );

    always #5 clk_in = ~clk_in;

    // Model: exactly one of want/pend/show/park holds; drop marks a pending response as dead.
    bit          started = 1'b0;
    bit          m_want, m_pend, m_drop, m_show, m_park, m_clear, m_justreset;
    logic [31:0] m_pc;
    int unsigned m_fetches, m_flushes;
    logic [63:0] exp_q[$];

    int vectors = 0;
    int errors  = 0;
    int n_pop   = 0;
    bit prev_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit busy;
        started     = 1'b1;
        m_justreset = 1'b0;
        if (!rst_in) begin
            m_pc = RESET_PC;
            m_want = 1; m_pend = 0; m_drop = 0; m_show = 0; m_park = 0; m_clear = 0;
            m_justreset = 1'b1;
            m_fetches = 0; m_flushes = 0;
        end else if (rdy_in) begin
            m_clear = flush_in;
            if (flush_in) begin
                busy = (m_pend && !mem_resp_valid) || (m_want && mem_req_ready);
                m_pc = flush_pc_in & ~32'h3;
                m_want = !busy; m_pend = busy; m_drop = busy; m_show = 0; m_park = 0;
                m_flushes++;
            end else if (m_want) begin
                if (mem_req_ready) begin
                    m_want = 0; m_pend = 1; m_drop = 0;
                end
            end else if (m_pend) begin
                if (mem_resp_valid) begin
                    m_pend = 0;
                    if (m_drop) m_want = 1;
                    else begin
                        m_show = 1;
                        exp_q.push_back({m_pc, mem_resp_data});
                        m_fetches++;
                    end
                end
            end else if (m_show) begin
                m_show = 0;
                if (stall_in) m_park = 1;
                else begin
                    m_want = 1;
                    m_pc = next_pc_in & ~32'h3;
                end
            end else if (m_park && jalr_valid_in) begin
                m_park = 0; m_want = 1;
                m_pc = jalr_target_in & ~32'h3;
            end
        end
    endtask

    task automatic drive(input int cyc);
        rst_in         = !(cyc < 3 || (cyc % 900) == 450);
        rdy_in         = $urandom_range(0, 99) >= 12;
        mem_req_ready  = $urandom_range(0, 99) < 60;
        mem_resp_valid = rst_in && rdy_in && m_pend && ($urandom_range(0, 99) < 50);
        mem_resp_data  = $urandom;
        stall_in       = $urandom_range(0, 99) < 35;
        next_pc_in     = $urandom;
        flush_in       = $urandom_range(0, 99) < 7;
        flush_pc_in    = $urandom;
        jalr_valid_in  = $urandom_range(0, 99) < 40;
        jalr_target_in = $urandom;
    endtask

    initial begin
        rst_in = 0; rdy_in = 1; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
        stall_in = 0; next_pc_in = 0; flush_in = 0; flush_pc_in = 0;
        jalr_valid_in = 0; jalr_target_in = 0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk_in);
            #1 model_step();
            #1 drive(cyc);
        end
        @(negedge clk_in);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("deliveries_seen", 64'(n_pop > 50), 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Monitor: per-cycle handshake checks plus scoreboard pop on each new delivery.
    always @(negedge clk_in) begin
        if (started) begin
            logic [63:0] exp;
            chk("mem_req_valid", 64'(mem_req_valid), 64'(m_want));
            if (m_want) chk("mem_req_addr", 64'(mem_req_addr), 64'(m_pc));
            chk("clear_out", 64'(clear_out), 64'(m_clear));
            chk("inst_ready_out", 64'(inst_ready_out), 64'(m_show));
            if (m_justreset) begin
                chk("reset_inst_out", 64'(inst_out), 64'd0);
                chk("reset_inst_addr_out", 64'(inst_addr_out), 64'd0);
            end
            if (inst_ready_out === 1'b1 && !prev_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_delivery", {inst_addr_out, inst_out}, 64'hx);
                end else begin
                    exp = exp_q.pop_front();
                    n_pop++;
                    chk("delivery_addr_data", {inst_addr_out, inst_out}, exp);
                end
            end
            prev_ready = (inst_ready_out === 1'b1);
`ifdef FETCH_PERF_EN
            chk("fetch_count_out", 64'(fetch_count_out), 64'(m_fetches));
            chk("flush_count_out", 64'(flush_count_out), 64'(m_flushes));
`endif
        end
    end

endmodule

// File: doc/inst_fetcher.md
# inst_fetcher

Front-end instruction fetch unit: owns the program counter, issues word-fetch requests to the instruction memory port, and presents each fetched instruction to the decoder with its address. Closes the loop with the decoder by consuming the decoder's predicted next PC and stall request, and handles pipeline flush redirects and JALR target resolution from the back end.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-low reset
- rdy_in  input  1  global ready; low freezes all state and registered outputs
- mem_req_valid  output  1  fetch request valid
- mem_req_addr  output  32  word address of request (bits [1:0] always 0)
- mem_req_ready  input  1  memory accepts request this cycle
- mem_resp_valid  input  1  response data valid (one cycle per accepted request)
- mem_resp_data  input  32  instruction word
- inst_out  output  32  instruction to decoder
- inst_ready_out  output  1  inst_out/inst_addr_out valid this cycle (single-cycle pulse)
- inst_addr_out  output  32  PC of inst_out
- clear_out  output  1  one-cycle flush notice to decoder
- stall_in  input  1  decoder requests hold (JALR seen)
- next_pc_in  input  32  decoder's predicted next PC
- flush_in  input  1  back-end mispredict/redirect
- flush_pc_in  input  32  redirect target
- jalr_valid_in  input  1  JALR target resolved
- jalr_target_in  input  32  resolved JALR target

## Operation
- States: REQ, WAIT, DELIVER, HOLD, DISCARD. Registered pc, state.
- REQ: mem_req_valid=1, mem_req_addr=pc. On mem_req_ready -> WAIT.
- WAIT: on mem_resp_valid, register inst_out<=mem_resp_data, inst_addr_out<=pc, inst_ready_out<=1 -> DELIVER.
- DELIVER (inst_ready_out=1): if stall_in -> HOLD, pc unchanged; else pc<=next_pc_in -> REQ. inst_ready_out clears on exit.
- HOLD: wait for jalr_valid_in; then pc<=jalr_target_in -> REQ.
- DISCARD: wait for the outstanding mem_resp_valid, drop data, -> REQ.
- Flush (flush_in=1) has priority over every other event in every state: pc<=flush_pc_in, clear_out<=1 next cycle, inst_ready_out<=0; next state REQ, except WAIT without same-cycle mem_resp_valid -> DISCARD. Flush in REQ coinciding with mem_req_ready -> DISCARD (request was accepted).
- Flush in DISCARD: update pc, stay DISCARD.
- All PC loads force bits [1:0] to 0; arithmetic is 32-bit wrapping (0xFFFF_FFFC + 4 -> 0 is decoder's concern; fetcher just loads).
- At most one request outstanding.

## Timing
- Reset (rst_in=0 at clock edge): pc=RESET_PC, state=REQ, inst_out=0, inst_addr_out=0, inst_ready_out=0, clear_out=0. mem_req_valid=1 first cycle after release.
- mem_req_valid/mem_req_addr are combinational from state/pc; all other outputs registered.
- Latency: response cycle N -> inst_ready_out high cycle N+1 -> next request asserted cycle N+2. Zero-wait memory: one instruction per 3 cycles.
- clear_out high exactly one cycle, the cycle after flush_in sampled.
- rdy_in=0: no state/pc/output register updates; inputs ignored that cycle; mem_resp_valid must not arrive while rdy_in=0.
- Reset mid-operation returns to REQ; an in-flight response after reset is the memory's responsibility to cancel.

## Configuration
- FETCH_PERF_EN defined: adds outputs fetch_count_out[31:0] (increments per inst_ready_out pulse) and flush_count_out[31:0] (increments per accepted flush_in), both reset to 0, wrap at 2^32, frozen when rdy_in=0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset RESET_PC=0x0, memory returns 0x00000013 (addi) at 0x0, decoder next_pc_in=0x4 -> requests 0x0 then 0x4; inst_ready_out pulses with inst_addr_out=0x0.
- JAL at 0x8, next_pc_in=0x100 during DELIVER -> next mem_req_addr=0x100.
- JALR at 0x10, stall_in=1 -> no requests issued until jalr_valid_in with target 0x203 -> mem_req_addr=0x200.
- flush_in with flush_pc_in=0x400 while WAIT, response arrives 3 cycles later -> response dropped (no inst_ready_out), clear_out pulse one cycle after flush, then request 0x400.
- flush_in same cycle as mem_resp_valid -> no delivery, direct REQ at flush target; flush during HOLD -> leaves HOLD to flush target.
- rdy_in low 5 cycles in DELIVER -> inst_ready_out stays high, pc unchanged; with FETCH_PERF_EN, fetch_count_out increments once per delivery only.
